acx_slave_reg_irq_bank: RTL and testbench

Parametrised interrupt register bank for the AXI slave register space: captures up to NUM_IRQ interrupt sources into a sticky STATUS register, gates them with a software ENABLE mask, and drives per-bit and aggregate interrupt outputs. Clearing is selectable: read-to-clear or write-1-to-clear. It sits on the shared register address/data bus alongside the other slave registers and decodes three consecutive word addresses.

---
 rtl/acx_slave_reg_irq_bank.sv | 138 +++++++++++++
 tb/tb_acx_slave_reg_irq_bank.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acx_slave_reg_irq_bank.sv
// Interrupt register bank: sticky STATUS, ENABLE mask and read-only PENDING view
// on the shared slave register bus, with selectable read-to-clear or write-1-to-clear.
module acx_slave_reg_irq_bank #(
  parameter int unsigned                TGT_ADDR_WIDTH = 28,
  parameter int unsigned                TGT_DATA_WIDTH = 32,
  parameter int unsigned                NUM_IRQ        = 32,
  parameter logic [TGT_ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
  parameter bit                         CLEAR_MODE     = 1'b0,
  parameter bit                         EDGE_DETECT    = 1'b0,
  parameter int unsigned                SYNC_STAGES    = 0,
  parameter logic [TGT_DATA_WIDTH-1:0]  STATUS_INIT    = '0,
  parameter logic [TGT_DATA_WIDTH-1:0]  ENABLE_INIT    = '0
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [TGT_DATA_WIDTH/8-1:0]   i_wr,
  input  logic                          i_rd,
  input  logic [TGT_ADDR_WIDTH-1:0]     i_addr,
  input  logic [TGT_DATA_WIDTH-1:0]     i_write_data,
  input  logic [NUM_IRQ-1:0]            i_irq_src,
  output logic                          o_addr_hit,
  output logic [TGT_DATA_WIDTH-1:0]     o_read_data,
  output logic [NUM_IRQ-1:0]            o_irq_vec,
  output logic                          o_irq
);

  localparam int unsigned NB = TGT_DATA_WIDTH / 8;
  localparam logic [TGT_ADDR_WIDTH-1:0] ADDR_STATUS  = BASE_ADDR;
  localparam logic [TGT_ADDR_WIDTH-1:0] ADDR_ENABLE  = BASE_ADDR + TGT_ADDR_WIDTH'(4);
  localparam logic [TGT_ADDR_WIDTH-1:0] ADDR_PENDING = BASE_ADDR + TGT_ADDR_WIDTH'(8);

  logic                      cs_status;
  logic                      cs_enable;
  logic                      cs_pending;
  logic                      cs_any;
  logic                      req;
  logic                      acc;
  logic                      acc_done;
  logic [TGT_DATA_WIDTH-1:0] byte_mask;
  logic [NUM_IRQ-1:0]        wr_bits;
  logic [TGT_DATA_WIDTH-1:0] rd_mux;
  logic [NUM_IRQ-1:0]        status_q;
  logic [NUM_IRQ-1:0]        enable_q;
  logic [NUM_IRQ-1:0]        src_s;
  logic [NUM_IRQ-1:0]        src_d;
  logic [NUM_IRQ-1:0]        set_vec;
  logic [NUM_IRQ-1:0]        clr_vec;

  assign req    = (|i_wr) | i_rd;
  assign cs_any = cs_status | cs_enable | cs_pending;
  assign acc    = cs_any & req & ~acc_done;

  always_comb begin
    byte_mask = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      byte_mask[b*8 +: 8] = {8{i_wr[b]}};
    end
  end

  assign wr_bits = byte_mask[NUM_IRQ-1:0];

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign src_s = i_irq_src;
    end else begin : g_sync
      logic [SYNC_STAGES*NUM_IRQ-1:0]     chain_q;
      logic [(SYNC_STAGES+1)*NUM_IRQ-1:0] shift_in;
      assign shift_in = {chain_q, i_irq_src};
      always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) chain_q <= '0;
        else         chain_q <= shift_in[SYNC_STAGES*NUM_IRQ-1:0];
      end
      assign src_s = chain_q[SYNC_STAGES*NUM_IRQ-1 -: NUM_IRQ];
    end
  endgenerate

  assign set_vec = EDGE_DETECT ? (src_s & ~src_d) : src_s;

  always_comb begin
    clr_vec = '0;
    if (acc && cs_status) begin
      if (!CLEAR_MODE && i_rd)
        clr_vec = '1;
      else if (CLEAR_MODE && (|i_wr))
        clr_vec = i_write_data[NUM_IRQ-1:0] & wr_bits;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (cs_status)
      rd_mux[NUM_IRQ-1:0] = status_q;
    else if (cs_enable)
      rd_mux[NUM_IRQ-1:0] = enable_q;
    else if (cs_pending)
      rd_mux[NUM_IRQ-1:0] = status_q & enable_q;
  end

  // Decode is qualified by req so a new request always sees the full two-edge latency.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cs_status   <= 1'b0;
      cs_enable   <= 1'b0;
      cs_pending  <= 1'b0;
      acc_done    <= 1'b0;
      o_addr_hit  <= 1'b0;
      o_read_data <= '0;
    end else begin
      cs_status  <= req && (i_addr === ADDR_STATUS);
      cs_enable  <= req && (i_addr === ADDR_ENABLE);
      cs_pending <= req && (i_addr === ADDR_PENDING);
      o_addr_hit <= acc;
      if (acc) begin
        o_read_data <= rd_mux;
        acc_done    <= 1'b1;
      end else if (!req || !cs_any) begin
        acc_done    <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      status_q <= STATUS_INIT[NUM_IRQ-1:0];
      enable_q <= ENABLE_INIT[NUM_IRQ-1:0];
      src_d    <= '0;
    end else begin
      src_d    <= src_s;
      status_q <= (status_q & ~clr_vec) | set_vec;
      if (acc && cs_enable && (|i_wr))
        enable_q <= (enable_q & ~wr_bits) | (i_write_data[NUM_IRQ-1:0] & wr_bits);
    end
  end

  assign o_irq_vec = status_q & enable_q;
  assign o_irq     = |o_irq_vec;

endmodule

// File: tb/tb_acx_slave_reg_irq_bank.sv
// Bench for acx_slave_reg_irq_bank: three configurations share one register bus,
// each tracked by a behavioural register model plus directed vector expectations.
module tb_acx_slave_reg_irq_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  wr = '0;
  logic        rd = 1'b0;
  logic [27:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] src [3] = '{32'h0, 32'h0, 32'h0};

  logic        hit0, hit1, hit2;
  logic [31:0] rdata0, rdata1, rdata2;
  logic [31:0] vec0, vec1;
  logic [11:0] vec2;
  logic        irq0, irq1, irq2;

  int n_checks = 0;
  int n_err    = 0;

  int unsigned p_n  [3] = '{32, 32, 12};
  bit          p_cm [3] = '{1'b0, 1'b1, 1'b0};
  bit          p_ed [3] = '{1'b1, 1'b0, 1'b0};
  logic [31:0] p_si [3] = '{32'h0, 32'h0, 32'hFFFF_F5A5};
  logic [31:0] p_ei [3] = '{32'h0, 32'h0, 32'h0000_000F};

  logic [31:0] m_status [3];
  logic [31:0] m_en     [3];
  logic [31:0] m_prev   [3];
  logic [31:0] m_rd     [3];

  always #5 clk = ~clk;

  acx_slave_reg_irq_bank #(.CLEAR_MODE(1'b0), .EDGE_DETECT(1'b1)) u0 (
    .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_rd(rd), .i_addr(addr),
    .i_write_data(wdata), .i_irq_src(src[0]), .o_addr_hit(hit0),
    .o_read_data(rdata0), .o_irq_vec(vec0), .o_irq(irq0));

  acx_slave_reg_irq_bank #(.CLEAR_MODE(1'b1), .EDGE_DETECT(1'b0)) u1 (
    .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_rd(rd), .i_addr(addr),
    .i_write_data(wdata), .i_irq_src(src[1]), .o_addr_hit(hit1),
    .o_read_data(rdata1), .o_irq_vec(vec1), .o_irq(irq1));

  acx_slave_reg_irq_bank #(.NUM_IRQ(12), .STATUS_INIT(32'hFFFF_F5A5),
                           .ENABLE_INIT(32'h0000_000F)) u2 (
    .i_clk(clk), .i_reset(rst), .i_wr(wr), .i_rd(rd), .i_addr(addr),
    .i_write_data(wdata), .i_irq_src(src[2][11:0]), .o_addr_hit(hit2),
    .o_read_data(rdata2), .o_irq_vec(vec2), .o_irq(irq2));

  function automatic logic [31:0] msk(input int k);
    logic [63:0] t;
    t = (64'd1 << p_n[k]) - 64'd1;
    return t[31:0];
  endfunction

  function automatic logic [31:0] bytemask(input logic [3:0] w);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (w[b]) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic dut_hit(input int k);
    case (k)
      0:       return hit0;
      1:       return hit1;
      default: return hit2;
    endcase
  endfunction

  function automatic logic [31:0] dut_rdata(input int k);
    case (k)
      0:       return rdata0;
      1:       return rdata1;
      default: return rdata2;
    endcase
  endfunction

  function automatic logic [31:0] dut_vec(input int k);
    case (k)
      0:       return vec0;
      1:       return vec1;
      default: return {20'h0, vec2};
    endcase
  endfunction

  function automatic logic dut_irq(input int k);
    case (k)
      0:       return irq0;
      1:       return irq1;
      default: return irq2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_status[k] = p_si[k] & msk(k);
      m_en[k]     = p_ei[k] & msk(k);
      m_prev[k]   = '0;
    end
  endtask

  task automatic chk_irq_outputs(input string tag);
    logic [31:0] pend;
    for (int k = 0; k < 3; k++) begin
      pend = m_status[k] & m_en[k];
      chk($sformatf("%s_vec%0d", tag, k), dut_vec(k), pend);
      chk($sformatf("%s_irq%0d", tag, k), {31'h0, dut_irq(k)}, {31'h0, |pend});
    end
  endtask

  task automatic chk_no_hit(input string tag);
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s_hit%0d", tag, k), {31'h0, dut_hit(k)}, 32'h0);
  endtask

  // Advance one clock; the model applies the register rules for that edge.
  task automatic step(input bit commit);
    logic [31:0] set, clr, bm, sel;
    bm = bytemask(wr);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_status[k] = p_si[k] & msk(k);
        m_en[k]     = p_ei[k] & msk(k);
        m_prev[k]   = '0;
      end else begin
        set       = (p_ed[k] ? (src[k] & ~m_prev[k]) : src[k]) & msk(k);
        m_prev[k] = src[k] & msk(k);
        clr       = '0;
        if (commit) begin
          case (addr)
            28'h0:   sel = m_status[k];
            28'h4:   sel = m_en[k];
            default: sel = m_status[k] & m_en[k];
          endcase
          m_rd[k] = sel;
          if (addr == 28'h0 && !p_cm[k] && rd)       clr = '1;
          if (addr == 28'h0 && p_cm[k] && wr != 4'h0) clr = wdata & bm;
          if (addr == 28'h4 && wr != 4'h0)
            m_en[k] = ((m_en[k] & ~bm) | (wdata & bm)) & msk(k);
        end
        m_status[k] = ((m_status[k] & ~clr) | set) & msk(k);
      end
    end
    @(posedge clk);
    #1;
    chk_irq_outputs("step");
  endtask

  task automatic access(input logic [27:0] a, input logic [3:0] w, input logic r,
                        input logic [31:0] d, input int hold, input logic [31:0] csrc);
    bit valid;
    bit cm;
    valid = (a == 28'h0) || (a == 28'h4) || (a == 28'h8);
    addr  = a;
    wr    = w;
    rd    = r;
    wdata = d;
    for (int c = 1; c <= hold; c++) begin
      cm = valid && (c == 2);
      if (c == 2 && csrc != 32'h0) src[0] = csrc;
      step(cm);
      if (c == 2 && csrc != 32'h0) src[0] = 32'h0;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("acc_hit%0d_c%0d", k, c), {31'h0, dut_hit(k)}, {31'h0, cm});
        if (cm) chk($sformatf("acc_rdata%0d", k), dut_rdata(k), m_rd[k]);
      end
    end
    wr = '0;
    rd = 1'b0;
    step(1'b0);
    chk_no_hit("acc_end");
  endtask

  typedef struct {
    string       name;
    logic [27:0] a;
    logic [3:0]  w;
    logic        r;
    logic [31:0] d;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t        tbl [$];
  int          idle;
  logic [27:0] ra;
  logic [3:0]  rw;
  logic        rr;

  initial begin
    tbl.push_back('{"rd_en_reset",  28'h4, 4'h0, 1'b1, 32'h0,         32'h0, 32'h0,  32'h0,        32'h0});
    tbl.push_back('{"rd_pend_en0",  28'h8, 4'h0, 1'b1, 32'h0,         32'h8, 32'h0F, 32'h0,        32'h0});
    tbl.push_back('{"wr_en_8",      28'h4, 4'hF, 1'b0, 32'h8,         32'h0, 32'h0,  32'h0,        32'h0});
    tbl.push_back('{"rd_pend",      28'h8, 4'h0, 1'b1, 32'h0,         32'h0, 32'h0,  32'h8,        32'h8});
    tbl.push_back('{"rd_stat_clr",  28'h0, 4'h0, 1'b1, 32'h0,         32'h0, 32'h0,  32'h8,        32'h0F});
    tbl.push_back('{"rd_stat_2",    28'h0, 4'h0, 1'b1, 32'h0,         32'h0, 32'h0,  32'h0,        32'h0F});
    tbl.push_back('{"w1c_05_b0",    28'h0, 4'h1, 1'b0, 32'h05,        32'h0, 32'h0,  32'h0,        32'h0F});
    tbl.push_back('{"w1c_nostrb",   28'h0, 4'hE, 1'b0, 32'hFF,        32'h0, 32'h0,  32'h0,        32'h0A});
    tbl.push_back('{"rd_stat_3",    28'h0, 4'h0, 1'b1, 32'h0,         32'h0, 32'h0,  32'h0,        32'h0A});
    tbl.push_back('{"wr_en_0",      28'h4, 4'hF, 1'b0, 32'h0,         32'h0, 32'h0,  32'h8,        32'h8});
    tbl.push_back('{"wr_en_byte2",  28'h4, 4'h4, 1'b0, 32'hAABBCCDD,  32'h0, 32'h0,  32'h0,        32'h0});
    tbl.push_back('{"rd_en_byte2",  28'h4, 4'h0, 1'b1, 32'h0,         32'h0, 32'h0,  32'h00BB0000, 32'h00BB0000});
    tbl.push_back('{"wr_rd_en",     28'h4, 4'hF, 1'b1, 32'h1234,      32'h0, 32'h0,  32'h00BB0000, 32'h00BB0000});
    tbl.push_back('{"rd_en_1234",   28'h4, 4'h0, 1'b1, 32'h0,         32'h0, 32'h0,  32'h1234,     32'h1234});

    model_reset();
    repeat (3) step(1'b0);
    #2 rst = 1'b0;
    chk_no_hit("reset");
    for (int k = 0; k < 3; k++) chk($sformatf("reset_rdata%0d", k), dut_rdata(k), 32'h0);
    chk("reset_vec0", vec0, 32'h0);
    chk("reset_vec2", {20'h0, vec2}, 32'h005);
    step(1'b0);

    foreach (tbl[i]) begin
      if (tbl[i].s0 != 32'h0 || tbl[i].s1 != 32'h0) begin
        src[0] = tbl[i].s0;
        src[1] = tbl[i].s1;
        step(1'b0);
        src[0] = 32'h0;
        src[1] = 32'h0;
        step(1'b0);
      end
      access(tbl[i].a, tbl[i].w, tbl[i].r, tbl[i].d, 2, 32'h0);
      chk({tbl[i].name, "_u0"}, rdata0, tbl[i].e0);
      chk({tbl[i].name, "_u1"}, rdata1, tbl[i].e1);
    end

    // Set wins over a same-edge read-to-clear.
    access(28'h4, 4'hF, 1'b0, 32'hFFFF_FFFF, 2, 32'h0);
    src[0] = 32'h8;
    step(1'b0);
    src[0] = 32'h0;
    step(1'b0);
    chk("setwin_pre_vec0", vec0, 32'h8);
    chk("setwin_pre_irq0", {31'h0, irq0}, 32'h1);
    access(28'h0, 4'h0, 1'b1, 32'h0, 2, 32'h20);
    chk("setwin_rdata0", rdata0, 32'h8);
    chk("setwin_post_vec0", vec0, 32'h20);

    // Held read: one acknowledge only; PENDING writes acknowledged and ignored.
    access(28'h8, 4'h0, 1'b1, 32'h0, 5, 32'h0);
    chk("hold_pend_rdata0", rdata0, 32'h20);
    access(28'h8, 4'hF, 1'b0, 32'hFFFF_FFFF, 2, 32'h0);
    chk("pend_wr_vec0", vec0, 32'h20);
    access(28'hC, 4'h0, 1'b1, 32'h0, 3, 32'h0);

    repeat (200) begin
      idle = $urandom_range(0, 3);
      for (int j = 0; j < idle; j++) begin
        src[0] = $urandom & $urandom;
        src[1] = $urandom & $urandom & $urandom;
        src[2] = $urandom & $urandom & 32'hFFF;
        step(1'b0);
      end
      ra = 28'($urandom_range(0, 3)) << 2;
      rw = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      rr = 1'($urandom_range(0, 1));
      if (rw == 4'h0 && !rr) rr = 1'b1;
      access(ra, rw, rr, $urandom, $urandom_range(2, 4), 32'h0);
    end

    // Asynchronous reset in the middle of an access.
    src[0] = 32'h0;
    src[1] = 32'h0;
    src[2] = 32'h0;
    step(1'b0);
    step(1'b0);
    addr = 28'h0;
    rd   = 1'b1;
    step(1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk_no_hit("rst_mid");
    chk_irq_outputs("rst_mid");
    rd = 1'b0;
    repeat (2) begin
      step(1'b0);
      chk_no_hit("rst_hold");
    end
    #2 rst = 1'b0;
    repeat (2) begin
      step(1'b0);
      chk_no_hit("rst_rel");
    end
    access(28'h0, 4'h0, 1'b1, 32'h0, 2, 32'h0);
    chk("rst_rd_u2", rdata2, 32'h0000_05A5);
    chk("rst_rd_u0", rdata0, 32'h0);
    chk("rst_rd_u1", rdata1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
